signed_divider_module: RTL and testbench
========================================

# signed_divider_module

Iterative signed 8-bit integer divider, the inverse operation to the team's pipelined LUT multiplier. It recovers a quotient and remainder from a 16-bit-range product path narrowed to 8-bit signed operands. It takes one operand pair per start pulse and runs a restoring shift-subtract loop, one bit per clock. It reports the result with a one-cycle done pulse and sits beside the multiplier in the arithmetic test datapath.

## Interface
Parameters:
- WIDTH, 8, operand and result width; all behaviour below is specified for 8.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on a rising edge of clk, honoured only when idle
- dividend  input  8  signed two's-complement numerator, captured with start
- divisor  input  8  signed two's-complement denominator, captured with start
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse; quotient/remainder/flags valid from this cycle on
- quotient  output  8  signed quotient, truncated toward zero
- remainder  output  8  signed remainder, sign follows dividend
- div_by_zero  output  1  result flag: divisor was 0
- overflow  output  1  result flag: -128 / -1

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1:
  - capture operand signs;
  - capture magnitudes |dividend| and |divisor| as 8-bit unsigned (|-128| = 128 fits);
  - clear the 9-bit partial remainder and bit counter;
  - go to CALC.
- CALC: one restoring step per clock, MSB first:
  - shift {partial remainder, dividend magnitude} left by 1;
  - if the partial remainder is >= |divisor|, subtract |divisor| and set the quotient bit to 1; otherwise set it to 0;
  - after 8 steps (counter 0..7), go to FIX.
- FIX:
  - negate the quotient magnitude if the operand signs differ;
  - negate the remainder magnitude if the dividend is negative;
  - load quotient, remainder, div_by_zero and overflow;
  - pulse done;
  - return to IDLE.
- Divisor = 0:
  - the loop still runs, so latency is unchanged;
  - outputs quotient = 8'h00, remainder = dividend, div_by_zero = 1, overflow = 0.
- Dividend = -128 with divisor = -1: quotient = 8'h80, remainder = 0, overflow = 1, div_by_zero = 0.
- Flags are cleared whenever a new start is accepted.
- start while busy is ignored and not queued.
- Outputs hold their last result until the next FIX or reset.

## Timing
- Reset (async, immediate): state IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, overflow = 0, counter = 0.
- start=1 sampled at edge E:
  - busy = 1 after E;
  - CALC steps occur at edges E+1 .. E+8;
  - FIX occurs at edge E+9.
- After edge E+9:
  - done = 1 for exactly one cycle, and busy = 0 in that same cycle;
  - results are valid there and held afterwards;
  - state is already IDLE.
- Back-to-back operation: start sampled at edge E+9 is ignored because the block is still busy. start sampled at E+10 is accepted, so throughput is one division per 10 clocks.
- dividend and divisor are sampled only at edge E; input changes during busy have no effect.
- Reset mid-operation aborts immediately:
  - all outputs return to reset values;
  - no done pulse is generated;
  - the first start after rst_n rises is accepted normally.

## Test plan
- Hold rst_n = 0 for 250 ns, release, clock period 50 ns → all outputs 0 and busy = 0 before the first start.
- 20 / 4, then -63 / 7 (start re-issued the cycle after the first done) → quotient 8'h05, remainder 0, then quotient 8'hF7 (-9), remainder 0; each done arrives exactly 9 edges after its start edge.
- Sign matrix:
  - -7 / 2 → q 8'hFD, r 8'hFF;
  - 7 / -2 → q 8'hFD, r 8'h01;
  - -7 / -2 → q 8'h03, r 8'hFF;
  - 127 / 1 → q 8'h7F, r 0.
- Exception cases:
  - 45 / 0 → q 0, r 8'h2D, div_by_zero = 1, overflow = 0;
  - -128 / -1 → q 8'h80, r 0, overflow = 1;
  - a following 9 / 3 → q 3 with both flags cleared.
- Pulse start for 3 consecutive cycles with changing operands → only the first pair is divided, exactly one done pulse.
- Assert rst_n = 0 at the 4th CALC edge → outputs cleared immediately, no done pulse; a fresh 100 / 7 afterwards → q 8'h0E, r 8'h02.

Source files
------------

// File: rtl/signed_divider_module.sv
// Iterative signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, sign fix-up and exception flags in a final cycle.
module signed_divider_module #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [WIDTH:0]          prem;
  logic [WIDTH-1:0]        qmag;
  logic [WIDTH-1:0]        dvs_mag;
  logic signed [WIDTH-1:0] dividend_r;
  logic                    neg_q, neg_r, zero_r, ovf_r;
  logic [WIDTH:0]          prem_sh, prem_sub;
  logic                    take;

  // Magnitude as unsigned; the most negative value maps onto itself, which
  // read as unsigned is exactly its magnitude.
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] m,
                                                input logic neg);
    return neg ? (~m + 1'b1) : m;
  endfunction

  always_comb begin
    prem_sh  = {prem[WIDTH-1:0], qmag[WIDTH-1]};
    prem_sub = prem_sh - {1'b0, dvs_mag};
    take     = (prem_sh >= {1'b0, dvs_mag});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      prem        <= '0;
      qmag        <= '0;
      dvs_mag     <= '0;
      dividend_r  <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r       <= dividend[WIDTH-1];
            qmag        <= abs_mag(dividend);
            dvs_mag     <= abs_mag(divisor);
            dividend_r  <= dividend;
            zero_r      <= (divisor == '0);
            ovf_r       <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
            prem        <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        // qmag doubles as the dividend shifter and the quotient collector
        CALC: begin
          prem <= take ? prem_sub : prem_sh;
          qmag <= {qmag[WIDTH-2:0], take};
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= zero_r;
          overflow    <= ovf_r;
          if (zero_r) begin
            quotient  <= '0;
            remainder <= dividend_r;
          end else begin
            quotient  <= cond_neg(qmag, neg_q);
            remainder <= cond_neg(prem[WIDTH-1:0], neg_r);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider_module.sv
// Randomized and directed bench for signed_divider_module against an
// integer-arithmetic reference model.
module tb_signed_divider_module;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic signed [7:0] dividend;
  logic signed [7:0] divisor;
  logic              busy;
  logic              done;
  logic signed [7:0] quotient;
  logic signed [7:0] remainder;
  logic              div_by_zero;
  logic              overflow;

  int total = 0;
  int bad   = 0;

  signed_divider_module #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #25 clk = ~clk;

  function automatic void ref_div(input int a, input int b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
    int tq, tr;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      tq = 0;
      tr = a;
      dz = 1'b1;
    end else if (a == -128 && b == -1) begin
      tq = 128;
      tr = 0;
      ov = 1'b1;
    end else begin
      tq = a / b;
      tr = a % b;
    end
    q = tq[7:0];
    r = tr[7:0];
  endfunction

  // Issues start now; sampled at the next rising edge. Returns #1 after the done edge.
  task automatic run_div(input int a, input int b, input string tag);
    logic [7:0] eq, er;
    logic       edz, eov;
    int         lat;
    ref_div(a, b, eq, er, edz, eov);
    dividend = a[7:0];
    divisor  = b[7:0];
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL %s busy_after_start got=%b want=1", tag, busy);
    end
    lat = -1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = k; break; end
    end
    total++;
    if (lat != 9) begin
      bad++; $display("FAIL %s latency got=%0d want=9", tag, lat);
    end
    total++;
    if (quotient !== eq) begin
      bad++; $display("FAIL %s quotient got=%h want=%h", tag, quotient, eq);
    end
    total++;
    if (remainder !== er) begin
      bad++; $display("FAIL %s remainder got=%h want=%h", tag, remainder, er);
    end
    total++;
    if (div_by_zero !== edz || overflow !== eov) begin
      bad++; $display("FAIL %s flags got dz=%b ov=%b want dz=%b ov=%b",
                      tag, div_by_zero, overflow, edz, eov);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s busy_at_done got=%b want=0", tag, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #250;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, div_by_zero, overflow} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {busy, done, div_by_zero, overflow});
    end
    total++;
    if (quotient !== 8'h00 || remainder !== 8'h00) begin
      bad++; $display("FAIL reset_data got q=%h r=%h want 00/00", quotient, remainder);
    end
  endtask

  task automatic test_basic();
    run_div(20, 4, "20/4");
    run_div(-63, 7, "-63/7");
    total++;
    if (quotient !== 8'hF7) begin
      bad++; $display("FAIL b2b_q got=%h want=f7", quotient);
    end
  endtask

  task automatic test_sign_matrix();
    run_div(-7, 2, "-7/2");
    run_div(7, -2, "7/-2");
    run_div(-7, -2, "-7/-2");
    run_div(127, 1, "127/1");
  endtask

  task automatic test_exceptions();
    run_div(45, 0, "45/0");
    run_div(-128, -1, "-128/-1");
    run_div(9, 3, "9/3");
  endtask

  task automatic test_start_held();
    int pulses, first;
    dividend = 8'sd53; divisor = 8'sd5; start = 1'b1;
    @(posedge clk); #1;
    dividend = 8'sd33; divisor = 8'sd4;
    @(posedge clk); #1;
    dividend = 8'sd100; divisor = 8'sd9;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; first = -1;
    for (int k = 3; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
        total++;
        if (quotient !== 8'h0A || remainder !== 8'h03) begin
          bad++; $display("FAIL held_result got q=%h r=%h want 0a/03", quotient, remainder);
        end
      end
    end
    total++;
    if (pulses != 1 || first != 9) begin
      bad++; $display("FAIL held_pulses got n=%0d at=%0d want n=1 at=9", pulses, first);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    dividend = 8'sd77; divisor = 8'sd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, div_by_zero, overflow} !== 4'b0000 || quotient !== 8'h00 || remainder !== 8'h00) begin
      bad++; $display("FAIL abort_clear got b=%b d=%b q=%h r=%h want all 0", busy, done, quotient, remainder);
    end
    pulses = 0;
    repeat (3) begin @(posedge clk); #1; if (done === 1'b1) pulses++; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; if (done === 1'b1) pulses++; end
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL abort_no_done got=%0d want=0", pulses);
    end
    run_div(100, 7, "100/7");
  endtask

  task automatic test_random();
    int a, b;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      if (i % 13 == 5) b = 0;
      if (i % 17 == 8) begin a = -128; b = -1; end
      if (i % 11 == 3) begin a = -128; end
      run_div(a, b, $sformatf("rnd%0d_%0d/%0d", i, a, b));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_matrix();
    test_exceptions();
    test_start_held();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
